// File: rtl/pc_seq_if.sv
// Fetch-side bundle of pc_seq: control requests in, fetch address and stack status out.
// The master drives requests (core or bench); the slave is the program counter.
interface pc_seq_if #(
    parameter int ADDR_W = 32,
    parameter int TGT_W  = 16
);
    logic              stall;
    logic              branch_en;
    logic              call_en;
    logic              ret_en;
    logic [TGT_W-1:0]  branch_target;
    logic [ADDR_W-1:0] ins_address;
    logic              halted;
    logic              ras_empty;
    logic              ras_full;
    logic              ras_err;

    modport master (
        output stall, branch_en, call_en, ret_en, branch_target,
        input  ins_address, halted, ras_empty, ras_full, ras_err
    );

    modport slave (
        input  stall, branch_en, call_en, ret_en, branch_target,
        output ins_address, halted, ras_empty, ras_full, ras_err
    );
endinterface

// File: rtl/pc_seq.sv
// Program counter with stall, halt-at-last-address, branch, and a circular
// call/return stack that flags overflow and underflow in a sticky error bit.
module pc_seq #(
    parameter int          ADDR_W    = 32,
    parameter int          TGT_W     = 16,
    parameter int unsigned STEP      = 4,
    parameter int unsigned LAST_ADDR = 32'h0000_03FC,
    parameter int          RAS_DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    pc_seq_if.slave  bus
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] LAST_V = ADDR_W'(LAST_ADDR);
    localparam logic [CNT_W-1:0]  FULL_V = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [ADDR_W-1:0] ras_d [RAS_DEPTH];

    logic [ADDR_W-1:0] seq_next;
    logic [ADDR_W-1:0] target_ext;

    assign seq_next   = (pc_q < LAST_V) ? pc_q + STEP_V : pc_q;
    assign target_ext = ADDR_W'(bus.branch_target);

    // Pushing at ptr+1 when full lands on the oldest entry, so overflow needs no special write path.
    always_comb begin
        pc_d  = pc_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        err_d = err_q;
        ras_d = ras_q;
        if (!bus.stall) begin
            if (bus.ret_en && cnt_q != '0) begin
                pc_d  = ras_q[ptr_q];
                ptr_d = ptr_q - PTR_W'(1);
                cnt_d = cnt_q - CNT_W'(1);
            end else if (bus.ret_en) begin
                err_d = 1'b1;
                pc_d  = seq_next;
            end else if (bus.call_en) begin
                ras_d[ptr_q + PTR_W'(1)] = pc_q + STEP_V;
                ptr_d = ptr_q + PTR_W'(1);
                pc_d  = target_ext;
                if (cnt_q == FULL_V) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (bus.branch_en) begin
                pc_d = target_ext;
            end else begin
                pc_d = seq_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Stack contents are meaningless after reset, so they are left out of the reset branch.
    always_ff @(posedge clk) begin
        ras_q <= ras_d;
    end

    assign bus.ins_address = pc_q;
    assign bus.halted      = (pc_q >= LAST_V);
    assign bus.ras_empty   = (cnt_q == '0);
    assign bus.ras_full    = (cnt_q == FULL_V);
    assign bus.ras_err     = err_q;
endmodule
